// File: rtl/seg_pkg.sv
// Shared constants for the min:sec timer.
//   SEG_0..SEG_9 : active-high 7-segment patterns, bit7 = a ... bit1 = g, bit0 = dp
//   SEG_BLANK    : all segments off
//   count_dir_t  : count direction as seen on the dir input
//   bcd_pair_to_bin : {tens, ones} BCD digits to a plain binary value
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'b11111100;
    localparam logic [7:0] SEG_1     = 8'b01100000;
    localparam logic [7:0] SEG_2     = 8'b11011010;
    localparam logic [7:0] SEG_3     = 8'b11110010;
    localparam logic [7:0] SEG_4     = 8'b01100110;
    localparam logic [7:0] SEG_5     = 8'b10110110;
    localparam logic [7:0] SEG_6     = 8'b10111110;
    localparam logic [7:0] SEG_7     = 8'b11100000;
    localparam logic [7:0] SEG_8     = 8'b11111110;
    localparam logic [7:0] SEG_9     = 8'b11110110;
    localparam logic [7:0] SEG_BLANK = 8'b00000000;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } count_dir_t;

    function automatic int unsigned bcd_pair_to_bin(input logic [3:0] tens,
                                                    input logic [3:0] ones);
        return ({28'd0, tens} * 32'd10) + {28'd0, ones};
    endfunction

endpackage

// File: rtl/min_sec_timer_if.sv
// Control and display bundle of the min:sec timer.
//   en, clr, dir, load, load_min, load_sec : controls into the timer
//   min_bcd, sec_bcd                       : current value, BCD {tens, ones}
//   tick, done                             : one-cycle status pulses
//   seg3..seg0                             : 7-segment drive, min tens .. sec ones
// slave = the timer, master = whatever drives it.
interface min_sec_timer_if;

    logic       en;
    logic       clr;
    logic       dir;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       tick;
    logic       done;
    logic [7:0] seg3;
    logic [7:0] seg2;
    logic [7:0] seg1;
    logic [7:0] seg0;

    modport slave (
        input  en, clr, dir, load, load_min, load_sec,
        output min_bcd, sec_bcd, tick, done, seg3, seg2, seg1, seg0
    );

    modport master (
        output en, clr, dir, load, load_min, load_sec,
        input  min_bcd, sec_bcd, tick, done, seg3, seg2, seg1, seg0
    );

endinterface

// File: rtl/seg7_dec.sv
// One-digit 7-segment decoder.
//   i_digit : BCD digit 0..9
//   o_seg   : segment pattern, bit7 = a ... bit1 = g, bit0 = dp (always off)
// ACTIVE_LOW = 1 inverts the pattern so a set bit leaves the segment dark.
// Codes above 9 decode to all segments dark.
module seg7_dec
    import seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] i_digit,
    output logic [7:0] o_seg
);

    logic [7:0] w_pattern;

    always_comb begin
        w_pattern = SEG_BLANK;
        case (i_digit)
            4'd0:    w_pattern = SEG_0;
            4'd1:    w_pattern = SEG_1;
            4'd2:    w_pattern = SEG_2;
            4'd3:    w_pattern = SEG_3;
            4'd4:    w_pattern = SEG_4;
            4'd5:    w_pattern = SEG_5;
            4'd6:    w_pattern = SEG_6;
            4'd7:    w_pattern = SEG_7;
            4'd8:    w_pattern = SEG_8;
            4'd9:    w_pattern = SEG_9;
            default: w_pattern = SEG_BLANK;
        endcase
    end

    assign o_seg = ACTIVE_LOW ? ~w_pattern : w_pattern;

endmodule

// File: rtl/min_sec_timer.sv
// Minutes:seconds up/down timer with 4-digit 7-segment drive.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : control inputs, BCD value, tick/done pulses and segment drive
// A prescaler turns TICK_DIV enabled clk cycles into one pending tick; the
// BCD chain advances on the following edge so tick is aligned with the new value.
// Priority per edge: reset > clr > valid load > tick advance.
module min_sec_timer
    import seg_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 8000000,
    parameter int unsigned MIN_MAX        = 59,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    min_sec_timer_if.slave  bus
);

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [3:0]    MAX_T      = 4'(MIN_MAX / 10);
    localparam logic [3:0]    MAX_O      = 4'(MIN_MAX % 10);

    logic [PW-1:0] r_presc;
    logic          r_pend;
    logic [3:0]    r_min_t;
    logic [3:0]    r_min_o;
    logic [3:0]    r_sec_t;
    logic [3:0]    r_sec_o;
    logic          r_tick;
    logic          r_done;

    count_dir_t    w_dir;
    logic [3:0]    w_ld_min_t;
    logic [3:0]    w_ld_min_o;
    logic [3:0]    w_ld_sec_t;
    logic [3:0]    w_ld_sec_o;
    logic          w_load_ok;
    logic          w_is_zero;
    logic [3:0]    w_nxt_min_t;
    logic [3:0]    w_nxt_min_o;
    logic [3:0]    w_nxt_sec_t;
    logic [3:0]    w_nxt_sec_o;
    logic          w_adv_done;

    assign w_dir      = count_dir_t'(bus.dir);
    assign w_ld_min_t = bus.load_min[7:4];
    assign w_ld_min_o = bus.load_min[3:0];
    assign w_ld_sec_t = bus.load_sec[7:4];
    assign w_ld_sec_o = bus.load_sec[3:0];

    assign w_load_ok = bus.load
                     && (w_ld_min_t <= 4'd9) && (w_ld_min_o <= 4'd9)
                     && (w_ld_sec_t <= 4'd5) && (w_ld_sec_o <= 4'd9)
                     && (bcd_pair_to_bin(w_ld_min_t, w_ld_min_o) <= MIN_MAX);

    assign w_is_zero = (r_min_t == 4'd0) && (r_min_o == 4'd0)
                     && (r_sec_t == 4'd0) && (r_sec_o == 4'd0);

    // Value the BCD chain takes on a tick in the current direction.
    always_comb begin
        w_nxt_min_t = r_min_t;
        w_nxt_min_o = r_min_o;
        w_nxt_sec_t = r_sec_t;
        w_nxt_sec_o = r_sec_o;
        w_adv_done  = 1'b0;
        if (w_dir == DIR_UP) begin
            if (r_sec_o != 4'd9) begin
                w_nxt_sec_o = r_sec_o + 4'd1;
            end else begin
                w_nxt_sec_o = 4'd0;
                if (r_sec_t != 4'd5) begin
                    w_nxt_sec_t = r_sec_t + 4'd1;
                end else begin
                    w_nxt_sec_t = 4'd0;
                    if ((r_min_t == MAX_T) && (r_min_o == MAX_O)) begin
                        w_nxt_min_t = 4'd0;
                        w_nxt_min_o = 4'd0;
                        w_adv_done  = 1'b1;
                    end else if (r_min_o != 4'd9) begin
                        w_nxt_min_o = r_min_o + 4'd1;
                    end else begin
                        w_nxt_min_o = 4'd0;
                        w_nxt_min_t = r_min_t + 4'd1;
                    end
                end
            end
        end else if (!w_is_zero) begin
            // 00:00 holds when counting down; any other value borrows normally.
            w_adv_done = (r_min_t == 4'd0) && (r_min_o == 4'd0)
                       && (r_sec_t == 4'd0) && (r_sec_o == 4'd1);
            if (r_sec_o != 4'd0) begin
                w_nxt_sec_o = r_sec_o - 4'd1;
            end else begin
                w_nxt_sec_o = 4'd9;
                if (r_sec_t != 4'd0) begin
                    w_nxt_sec_t = r_sec_t - 4'd1;
                end else begin
                    w_nxt_sec_t = 4'd5;
                    if (r_min_o != 4'd0) begin
                        w_nxt_min_o = r_min_o - 4'd1;
                    end else begin
                        w_nxt_min_o = 4'd9;
                        w_nxt_min_t = r_min_t - 4'd1;
                    end
                end
            end
        end
    end

    // r_pend marks that the prescaler wrapped on the previous edge; the
    // advance it triggers happens regardless of en, so a tick already earned
    // is never stretched by a pause. clr and a valid load discard it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_pend  <= 1'b0;
            r_min_t <= 4'd0;
            r_min_o <= 4'd0;
            r_sec_t <= 4'd0;
            r_sec_o <= 4'd0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.clr) begin
            r_presc <= '0;
            r_pend  <= 1'b0;
            r_min_t <= 4'd0;
            r_min_o <= 4'd0;
            r_sec_t <= 4'd0;
            r_sec_o <= 4'd0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_load_ok) begin
            r_presc <= '0;
            r_pend  <= 1'b0;
            r_min_t <= w_ld_min_t;
            r_min_o <= w_ld_min_o;
            r_sec_t <= w_ld_sec_t;
            r_sec_o <= w_ld_sec_o;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tick <= r_pend;
            r_done <= r_pend & w_adv_done;
            if (r_pend) begin
                r_min_t <= w_nxt_min_t;
                r_min_o <= w_nxt_min_o;
                r_sec_t <= w_nxt_sec_t;
                r_sec_o <= w_nxt_sec_o;
            end
            if (bus.en) begin
                if (r_presc == PRESC_LAST) begin
                    r_presc <= '0;
                    r_pend  <= 1'b1;
                end else begin
                    r_presc <= r_presc + PRESC_ONE;
                    r_pend  <= 1'b0;
                end
            end else begin
                r_pend <= 1'b0;
            end
        end
    end

    assign bus.min_bcd = {r_min_t, r_min_o};
    assign bus.sec_bcd = {r_sec_t, r_sec_o};
    assign bus.tick    = r_tick;
    assign bus.done    = r_done;

    seg7_dec #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_min_t (.i_digit(r_min_t), .o_seg(bus.seg3));
    seg7_dec #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_min_o (.i_digit(r_min_o), .o_seg(bus.seg2));
    seg7_dec #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_sec_t (.i_digit(r_sec_t), .o_seg(bus.seg1));
    seg7_dec #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_sec_o (.i_digit(r_sec_o), .o_seg(bus.seg0));

endmodule

// File: tb/tb_min_sec_timer.sv
// Bench for min_sec_timer: stimulus pushes the expected post-edge value into a
// queue from a seconds-as-integer reference; a monitor pops and compares on
// every negedge.
module tb_min_sec_timer;

    localparam int TD   = 4;
    localparam int MM   = 59;
    localparam int NSEC = (MM + 1) * 60;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    min_sec_timer_if bus ();

    min_sec_timer #(
        .TICK_DIV       (TD),
        .MIN_MAX        (MM),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int   ed;
        int   v;
        logic tk;
        logic dn;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   dut_ticks = 0;
    int   dut_dones = 0;

    logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    // reference state: value as a plain count of seconds, prescaler as a
    // count of enabled cycles
    int m_v = 0;
    int m_pc = 0;
    bit m_pend = 1'b0;
    int m_ticks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    endtask

    function automatic logic [7:0] to_bcd(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic [31:0] exp_segs(input int v);
        int mi;
        int se;
        mi = v / 60;
        se = v % 60;
        return {~seg_tab[mi / 10], ~seg_tab[mi % 10], ~seg_tab[se / 10], ~seg_tab[se % 10]};
    endfunction

    task automatic step(input bit rst, input bit en, input bit clr, input bit dir,
                        input bit load, input logic [7:0] lmin, input logic [7:0] lsec);
        bit ok;
        bit tk;
        bit dn;
        int lm;
        int ls;
        rst_n        = rst ? 1'b0 : 1'b1;
        bus.en       = en;
        bus.clr      = clr;
        bus.dir      = dir;
        bus.load     = load;
        bus.load_min = lmin;
        bus.load_sec = lsec;
        lm = int'(lmin[7:4]) * 10 + int'(lmin[3:0]);
        ls = int'(lsec[7:4]) * 10 + int'(lsec[3:0]);
        ok = load && (lmin[7:4] <= 4'd9) && (lmin[3:0] <= 4'd9)
                  && (lsec[7:4] <= 4'd5) && (lsec[3:0] <= 4'd9) && (lm <= MM);
        tk = 1'b0;
        dn = 1'b0;
        if (rst || clr) begin
            m_v = 0; m_pc = 0; m_pend = 1'b0;
        end else if (ok) begin
            m_v = lm * 60 + ls; m_pc = 0; m_pend = 1'b0;
        end else begin
            if (m_pend) begin
                tk = 1'b1;
                if (!dir) begin
                    if (m_v == NSEC - 1) begin m_v = 0; dn = 1'b1; end
                    else m_v = m_v + 1;
                end else if (m_v > 0) begin
                    m_v = m_v - 1;
                    dn = (m_v == 0);
                end
            end
            m_pend = 1'b0;
            if (en) begin
                m_pc = m_pc + 1;
                if (m_pc == TD) begin m_pc = 0; m_pend = 1'b1; end
            end
        end
        if (tk) m_ticks++;
        exp_q.push_back('{edge_cnt + 1, m_v, tk, dn});
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n, input bit en, input bit dir);
        int start;
        int guard;
        start = m_ticks;
        guard = 0;
        while ((m_ticks - start) < n && guard < 2000) begin
            step(1'b0, en, 1'b0, dir, 1'b0, 8'h00, 8'h00);
            guard++;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.tick === 1'b1) dut_ticks++;
            if (bus.done === 1'b1) dut_dones++;
            if (exp_q.size() > 0 && exp_q[0].ed == edge_cnt) begin
                e = exp_q.pop_front();
                check("min_bcd", {24'd0, bus.min_bcd}, {24'd0, to_bcd(e.v / 60)});
                check("sec_bcd", {24'd0, bus.sec_bcd}, {24'd0, to_bcd(e.v % 60)});
                check("segs", {bus.seg3, bus.seg2, bus.seg1, bus.seg0}, exp_segs(e.v));
                check("tick_done", {30'd0, bus.tick, bus.done}, {30'd0, e.tk, e.dn});
            end
        end
    end

    initial begin
        int t0;
        int d0;
        int guard;
        bit rdir;
        logic [7:0] lmin;
        logic [7:0] lsec;
        int mm;
        int ss;

        // reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("rst_min", {24'd0, bus.min_bcd}, 32'h00);
        check("rst_sec", {24'd0, bus.sec_bcd}, 32'h00);
        check("rst_segs", {bus.seg3, bus.seg2, bus.seg1, bus.seg0}, 32'h03030303);
        check("rst_tick_done", {30'd0, bus.tick, bus.done}, 32'h0);

        // up count to 01:00
        guard = 0;
        while (m_v != 60 && guard < 400) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            guard++;
        end
        check("up_sec", {24'd0, bus.sec_bcd}, 32'h00);
        check("up_min", {24'd0, bus.min_bcd}, 32'h01);
        check("up_seg2", {24'd0, bus.seg2}, 32'h9F);

        // up wrap 59:58 -> 00:00
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h59, 8'h58);
        settle();
        d0 = dut_dones;
        run_ticks(2, 1'b1, 1'b0);
        settle();
        check("wrap_val", {16'd0, bus.min_bcd, bus.sec_bcd}, 32'h0000);
        check("wrap_done_cnt", dut_dones - d0, 1);

        // down count and saturation
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 8'h01);
        run_ticks(2, 1'b1, 1'b1);
        check("down_borrow", {16'd0, bus.min_bcd, bus.sec_bcd}, 32'h0059);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h02);
        settle();
        d0 = dut_dones;
        run_ticks(2, 1'b1, 1'b1);
        settle();
        check("down_zero", {16'd0, bus.min_bcd, bus.sec_bcd}, 32'h0000);
        check("down_done_cnt", dut_dones - d0, 1);
        d0 = dut_dones;
        t0 = dut_ticks;
        run_ticks(3, 1'b1, 1'b1);
        settle();
        check("sat_val", {16'd0, bus.min_bcd, bus.sec_bcd}, 32'h0000);
        check("sat_done_cnt", dut_dones - d0, 0);
        check("sat_tick_cnt", dut_ticks - t0, 3);

        // pause mid-second
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h10);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        settle();
        t0 = dut_ticks;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("pause_val", {24'd0, bus.sec_bcd}, 32'h10);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        settle();
        check("resume_no_tick", dut_ticks - t0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        settle();
        check("resume_tick", dut_ticks - t0, 1);
        check("resume_val", {24'd0, bus.sec_bcd}, 32'h11);

        // invalid loads
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h60);
        check("bad_sec_load", {16'd0, bus.min_bcd, bus.sec_bcd}, 32'h0011);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h00);
        check("bad_min_load", {16'd0, bus.min_bcd, bus.sec_bcd}, 32'h0011);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h60, 8'h00);
        check("over_max_load", {16'd0, bus.min_bcd, bus.sec_bcd}, 32'h0011);

        // clr + load + tick together
        guard = 0;
        while (!m_pend && guard < 20) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            guard++;
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34);
        check("clr_prio_val", {16'd0, bus.min_bcd, bus.sec_bcd}, 32'h0000);
        check("clr_prio_tick", {31'd0, bus.tick}, 32'h0);
        settle();
        t0 = dut_ticks;
        for (int i = 0; i < TD; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        settle();
        check("clr_presc_zero", dut_ticks - t0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        settle();
        check("clr_first_tick", dut_ticks - t0, 1);

        // load coinciding with a tick drops the tick
        guard = 0;
        while (!m_pend && guard < 20) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            guard++;
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 8'h34);
        check("load_prio_val", {16'd0, bus.min_bcd, bus.sec_bcd}, 32'h1234);
        check("load_prio_tick", {31'd0, bus.tick}, 32'h0);

        // reset beats load
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 8'h34);
        check("rst_prio_val", {16'd0, bus.min_bcd, bus.sec_bcd}, 32'h0000);

        // randomized traffic
        rdir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit r_rst;
            bit r_en;
            bit r_clr;
            bit r_ld;
            if ($urandom_range(0, 99) == 0) rdir = ~rdir;
            r_rst = ($urandom_range(0, 399) == 0);
            r_clr = ($urandom_range(0, 79) == 0);
            r_ld  = ($urandom_range(0, 24) == 0);
            r_en  = ($urandom_range(0, 99) < 85);
            case ($urandom_range(0, 2))
                0: begin
                    lmin = 8'($urandom);
                    lsec = 8'($urandom);
                end
                1: begin
                    mm = $urandom_range(0, MM);
                    ss = $urandom_range(0, 59);
                    lmin = to_bcd(mm);
                    lsec = to_bcd(ss);
                end
                default: begin
                    mm = rdir ? 0 : MM;
                    ss = rdir ? $urandom_range(0, 3) : $urandom_range(56, 59);
                    lmin = to_bcd(mm);
                    lsec = to_bcd(ss);
                end
            endcase
            step(r_rst, r_en, r_clr, rdir, r_ld, lmin, lsec);
        end

        repeat (3) @(negedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/min_sec_timer.md
Name: min_sec_timer

Overview:
- Parametrised minutes:seconds up/down timer with 4-digit 7-segment drive.
- Prescaler divides the board `clk` to a one-second tick.
- BCD counters hold MM:SS in the range 00:00 to 59:59; count direction is selectable and the value is loadable.
- Sits at the top of the counter lab, replacing the free-running seconds-only counter; drives `seg0`..`seg3` directly.

Parameters:
- TICK_DIV, 8000000, `clk` cycles per one-second tick (must be ≥2).
- MIN_MAX, 59, maximum minutes value (≤99); seconds are always mod 60.
- SEG_ACTIVE_LOW, 1, 1 = inverted segment outputs (pattern bit set = segment dark).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  1 = run (prescaler and counters advance); 0 = pause, all state held.
- clr  in  1  synchronous clear to 00:00 and prescaler to 0.
- dir  in  1  0 = count up, 1 = count down.
- load  in  1  1-cycle strobe to load `load_min`/`load_sec`.
- load_min  in  8  BCD minutes {tens, ones}.
- load_sec  in  8  BCD seconds {tens, ones}.
- min_bcd  out  8  current minutes, BCD.
- sec_bcd  out  8  current seconds, BCD.
- tick  out  1  1-cycle pulse on each one-second advance.
- done  out  1  1-cycle pulse on reaching 00:00 in down mode, or on wrap MIN_MAX:59 -> 00:00 in up mode.
- seg3, seg2, seg1, seg0  out  8 each  min tens, min ones, sec tens, sec ones; bit7 = a … bit1 = g, bit0 = dp.

Behaviour:
- Reset (`rst_n`=0 at posedge `clk`):
  - prescaler = 0; all BCD digits = 0; `tick` = 0; `done` = 0.
  - Each `seg` shows "0": 8'b00000011 when SEG_ACTIVE_LOW=1.
- Priority per cycle: reset > `clr` > `load` > tick advance.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while `en`=1.
  - At TICK_DIV-1 with `en`=1: wraps to 0 and the tick fires. Fires once every TICK_DIV enabled cycles.
  - `en`=0 freezes the prescaler, so pause/resume does not lose the partial second.
- Tick advance: `tick` and the counter update occur in the cycle after the prescaler hits TICK_DIV-1, so `tick` is registered and aligned with the new value.
- Up (`dir`=0):
  - sec ones 9 -> 0 carries into sec tens.
  - sec 59 -> 00 carries into minutes.
  - Minutes at MIN_MAX with sec 59 wraps to 00:00 and pulses `done`.
- Down (`dir`=1):
  - sec 00 -> 59 borrows from minutes.
  - 00:01 -> 00:00 pulses `done`.
  - At 00:00 further ticks hold 00:00: no wrap, no further `done`, but `tick` still pulses.
- `dir` changes take effect on the next tick; the prescaler is unaffected.
- `clr`: counters -> 00:00 and prescaler -> 0 next edge; `tick`/`done` = 0 that cycle. A `load` in the same cycle is ignored.
- `load`:
  - Accepted only if every digit is ≤9, sec tens ≤5, and the minutes value is ≤MIN_MAX.
  - Invalid load is ignored; state is unchanged.
  - A valid load also zeroes the prescaler.
  - A tick coinciding with `load` is dropped; `done` is not generated by a load.
- Segment outputs:
  - Combinational decode of the registered digits.
  - Digits >9 cannot occur; the decoder default is all segments dark.
  - dp is always off.
  - Display updates in the same cycle as `min_bcd`/`sec_bcd`.
- Reset mid-count: the next edge returns to 00:00 with prescaler 0, regardless of `en`/`load`.

Decomposition:
- Package `seg_pkg`: SEG_0..SEG_9 8-bit active-high patterns (0 = 8'b11111100, 1 = 8'b01100000, 2 = 8'b11011010, 3 = 8'b11110010, 4 = 8'b01100110, 5 = 8'b10110110, 6 = 8'b10111110, 7 = 8'b11100000, 8 = 8'b11111110, 9 = 8'b11110110) and SEG_BLANK = 8'b0.
- Sub-module `seg7_dec`: 4-bit digit -> 8-bit pattern, with an active-low option; instantiated 4 times.
- Prescaler and BCD counter chain stay in `min_sec_timer`.

Test Plan:
- Reset / power-up: TICK_DIV=4; hold `rst_n`=0 2 cycles -> `min_bcd`=00, `sec_bcd`=00, all `seg`=8'h03, `tick`=0, `done`=0.
- Up-count carry: `en`=1, `dir`=0, TICK_DIV=4:
  - `tick` every 4 cycles.
  - After 60 ticks -> 01:00 (`sec_bcd`=8'h00, `min_bcd`=8'h01); `seg2`=~8'b01100000.
- Up wrap: load 59:58, run 2 ticks -> 00:00 with `done` pulsing exactly 1 cycle, coincident with `tick`.
- Down count and saturation: `dir`=1, load 01:01 -> after 2 ticks 00:59; load 00:02 -> after 2 ticks 00:00 with `done`=1 once; 3 more ticks -> stays 00:00, `done`=0, `tick` still pulses.
- Pause and invalid load:
  - `en`=0 for 10 cycles mid-second -> value and prescaler frozen; resume -> next `tick` at the remaining count.
  - Load `load_sec`=8'h60 -> ignored.
  - Load `load_min`=8'h5A -> ignored.
- Priority: assert `clr`, `load` (12:34) and a tick in the same cycle -> 00:00, prescaler 0, `tick`=0; `rst_n`=0 with `load` -> 00:00.
